// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic-light front end.
// Used by the request conditioner and its bench.
package tl_pkg;

  localparam int DEFAULT_NUM_LIGHTS = 4;

  typedef logic [$clog2(DEFAULT_NUM_LIGHTS)-1:0] light_idx_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a counting debouncer for one raw input.
// The rise output is combinational and pulses in the cycle the stable value flips 0->1.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  always_comb begin
    flip     = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
    stable_d = flip ? sync2_q : stable_q;
    if ((sync2_q == stable_q) || flip) cnt_d = '0;
    else                               cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = flip & sync2_q;

endmodule

// File: rtl/request_conditioner.sv
// Conditions operator/field inputs for the four-approach sequencer: debounce,
// latch presses until served, and round-robin grant one preferential at a time.
module request_conditioner
  import tl_pkg::*;
#(
  parameter int NUM_LIGHTS      = DEFAULT_NUM_LIGHTS,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  raw_attention,
  input  logic [NUM_LIGHTS-1:0] raw_preferential,
  input  logic [NUM_LIGHTS-1:0] raw_force_red,
  input  logic                  attention_clr,
  input  logic [NUM_LIGHTS-1:0] served,
  output logic                  attention,
  output logic [NUM_LIGHTS-1:0] preferentials,
  output logic [NUM_LIGHTS-1:0] force_reds,
  output logic [NUM_LIGHTS-1:0] pending
);

  localparam int IW = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
  typedef logic [IW-1:0] idx_t;

  // Debouncer outputs this block has no use for are parked on *_unused nets.
  logic                  att_rise, att_stable_unused;
  logic [NUM_LIGHTS-1:0] pref_rise, pref_stable_unused;
  logic [NUM_LIGHTS-1:0] fr_stable, fr_rise_unused;

  logic                  attention_q, attention_d;
  logic [NUM_LIGHTS-1:0] pending_q, pending_d, eligible, prefs;
  arb_state_t            state_q, state_d;
  idx_t                  grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick, cand;
  logic                  found;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_att (
    .clk(clk), .rst(rst), .raw(raw_attention), .stable(att_stable_unused), .rise(att_rise)
  );

  for (genvar i = 0; i < NUM_LIGHTS; i++) begin : g_in
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pref (
      .clk(clk), .rst(rst), .raw(raw_preferential[i]),
      .stable(pref_stable_unused[i]), .rise(pref_rise[i])
    );
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fr (
      .clk(clk), .rst(rst), .raw(raw_force_red[i]),
      .stable(fr_stable[i]), .rise(fr_rise_unused[i])
    );
  end

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    attention_d = attention_q;
    if (attention_clr) attention_d = 1'b0;
    if (att_rise)      attention_d = 1'b1;
    pending_d = pref_rise | (pending_q & ~(served & prefs));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attention_q <= 1'b0;
      pending_q   <= '0;
    end else begin
      attention_q <= attention_d;
      pending_q   <= pending_d;
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_LIGHTS.
  always_comb begin
    eligible = pending_q & ~fr_stable;
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = 0; k < NUM_LIGHTS; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % NUM_LIGHTS);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d = ARB_GRANT;
          grant_d = pick;
        end
      end
      ARB_GRANT: begin
        // Force-red revokes without advancing the pointer and wins over served.
        if (fr_stable[grant_q]) begin
          state_d = ARB_IDLE;
        end else if (served[grant_q]) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IW'((int'(grant_q) + 1) % NUM_LIGHTS);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    prefs = '0;
    if (state_q == ARB_GRANT) prefs[grant_q] = 1'b1;
  end

  assign attention     = attention_q;
  assign preferentials = prefs;
  assign force_reds    = fr_stable;
  assign pending       = pending_q;

endmodule

// File: tb/tb_request_conditioner.sv
// Directed bench for request_conditioner with DEBOUNCE_CYCLES=4; expected grants
// are queued when presses are driven and popped when the grant appears.
module tb_request_conditioner;
  import tl_pkg::*;

  localparam int NL = DEFAULT_NUM_LIGHTS;

  logic          clk, rst;
  logic          raw_attention, attention_clr, attention;
  logic [NL-1:0] raw_preferential, raw_force_red, served;
  logic [NL-1:0] preferentials, force_reds, pending;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string         tag;
    logic [NL-1:0] exp;
  } sb_item_t;
  sb_item_t sb_q[$];

  request_conditioner #(.NUM_LIGHTS(NL), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .raw_attention(raw_attention), .raw_preferential(raw_preferential),
    .raw_force_red(raw_force_red), .attention_clr(attention_clr), .served(served),
    .attention(attention), .preferentials(preferentials),
    .force_reds(force_reds), .pending(pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sb_push(input string tag, input logic [NL-1:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  // Waits up to budget edges for a grant, then compares it with the oldest queued expectation.
  task automatic wait_grant(input int budget);
    sb_item_t it;
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (n < budget && preferentials == '0);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed=%0h expected=none", preferentials);
    end else begin
      it = sb_q.pop_front();
      check(it.tag, preferentials, it.exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    raw_attention = 1'b0;
    attention_clr = 1'b0;
    raw_preferential = '0;
    raw_force_red = '0;
    served = '0;
    #2;
    check("rst_attention", attention, 0);
    check("rst_prefs", preferentials, 0);
    check("rst_force", force_reds, 0);
    check("rst_pending", pending, 0);
    tick(2);
    rst = 1'b0;
    check("rst_rr_ptr", dut.rr_ptr_q, 0);

    // Attention: set at the 6th edge, held after release, cleared by attention_clr.
    raw_attention = 1'b1;
    tick(5);
    check("att_edge5", attention, 0);
    tick(1);
    check("att_edge6", attention, 1);
    tick(4);
    raw_attention = 1'b0;
    tick(8);
    check("att_held", attention, 1);
    attention_clr = 1'b1;
    tick(1);
    attention_clr = 1'b0;
    check("att_clr", attention, 0);

    // Three-cycle glitch on approach 2 is rejected.
    raw_preferential[2] = 1'b1;
    tick(3);
    raw_preferential[2] = 1'b0;
    tick(10);
    check("glitch_pending", pending, 0);
    check("glitch_prefs", preferentials, 0);
    check("glitch_att", attention, 0);

    // Simultaneous presses on 3 and 0 with rr_ptr=0.
    raw_preferential = 4'b1001;
    tick(6);
    raw_preferential = '0;
    check("dual_pending", pending, 4'b1001);
    check("dual_not_yet", preferentials, 0);
    sb_push("dual_grant0", 4'b0001);
    sb_push("dual_grant3", 4'b1000);
    wait_grant(1);
    served = 4'b0001;
    tick(1);
    served = '0;
    check("served0_idle", preferentials, 0);
    check("served0_rr", dut.rr_ptr_q, 1);
    check("served0_pending", pending, 4'b1000);
    wait_grant(1);
    served = 4'b1000;
    tick(1);
    served = '0;
    check("served3_pending", pending, 0);
    check("served3_prefs", preferentials, 0);
    check("served3_rr_wrap", dut.rr_ptr_q, 0);

    // Grant on 1, then force-red on 1 revokes it and keeps the request.
    raw_preferential[1] = 1'b1;
    tick(6);
    raw_preferential[1] = 1'b0;
    sb_push("fr_grant1", 4'b0010);
    wait_grant(1);
    raw_force_red[1] = 1'b1;
    tick(6);
    check("fr_level", force_reds, 4'b0010);
    check("fr_grant_still", preferentials, 4'b0010);
    tick(1);
    check("fr_revoked", preferentials, 0);
    check("fr_pending_kept", pending, 4'b0010);
    tick(3);
    check("fr_no_regrant", preferentials, 0);
    check("fr_rr_kept", dut.rr_ptr_q, 0);
    raw_force_red[1] = 1'b0;
    tick(5);
    check("fr_release_e5", force_reds, 4'b0010);
    tick(1);
    check("fr_release_e6", force_reds, 0);
    sb_push("fr_regrant1", 4'b0010);
    wait_grant(1);

    // served[1] coincides with a fresh press on 1: request survives, regranted after one idle cycle.
    raw_preferential[1] = 1'b1;
    tick(5);
    served = 4'b0010;
    tick(1);
    served = '0;
    check("setwin_prefs", preferentials, 0);
    check("setwin_pending", pending, 4'b0010);
    check("setwin_rr", dut.rr_ptr_q, 2);
    sb_push("setwin_regrant", 4'b0010);
    wait_grant(1);

    // Reset mid-count and mid-grant; held raw inputs re-debounce from scratch.
    raw_attention = 1'b1;
    tick(4);
    check("mid_count", dut.u_att.cnt_q, 2);
    rst = 1'b1;
    #1;
    check("midrst_att", attention, 0);
    check("midrst_prefs", preferentials, 0);
    check("midrst_pending", pending, 0);
    check("midrst_force", force_reds, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(5);
    check("redeb_e5_att", attention, 0);
    check("redeb_e5_pending", pending, 0);
    tick(1);
    check("redeb_e6_att", attention, 1);
    check("redeb_e6_pending", pending, 4'b0010);
    sb_push("redeb_grant", 4'b0010);
    wait_grant(1);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
